load_use_interlock: RTL and testbench
=====================================

Name: load_use_interlock

Overview:
- Scoreboard-based interlock controller for the 5-stage LA32R pipeline.
- Tracks destination registers of loads issued from ID into EXE whose data is not yet forwardable.
- Drives the ID stage `stall` input so a dependent instruction is held in ID until the EX/MEM forwarding paths carry the load data.
- Also gates ID→EXE issue, exposes the pending-register bitmap, and counts interlock stall cycles for performance debug.

Parameters:
- LOAD_LAT, 1, advance ticks from load issue (ID→EXE edge) until load data is forwardable to ID; legal range 1..7.
- CNT_W, 3, width of each per-register countdown; must satisfy 2^CNT_W > LOAD_LAT.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ds_valid  in  1  ID stage holds a valid instruction.
- ds_rf_re1  in  1  ID instruction reads ds_rf_raddr1.
- ds_rf_raddr1  in  5  ID read address 1 (rj).
- ds_rf_re2  in  1  ID instruction reads ds_rf_raddr2.
- ds_rf_raddr2  in  5  ID read address 2 (rk or rd).
- ds_is_load  in  1  ID instruction is ld.w.
- ds_rf_waddr  in  5  ID destination register.
- es_allow_in  in  1  EXE can accept an instruction.
- lat_tick  in  1  load pipeline advanced this cycle; tie high for a fixed-latency memory.
- flush  in  1  kill all in-flight loads (exception/ertn path).
- ds_stall  out  1  interlock request to ID `stall`.
- issue_fire  out  1  ID→EXE transfer occurs this cycle.
- sb_busy  out  32  pending-load bitmap; bit n set means rn is not yet forwardable.
- stall_cnt  out  32  number of cycles with ds_valid & ds_stall.

Behaviour:
- Reset (async, immediate): all countdowns = 0; sb_busy = 0; stall_cnt = 0; ds_stall = 0; issue_fire = 0.
- State: 32 countdowns cnt[n] of CNT_W bits. Entry 0 is hardwired to 0.
- sb_busy[n] = (cnt[n] != 0). This output is registered-state derived and has no combinational path from inputs.
- hit1 = ds_rf_re1 & (ds_rf_raddr1 != 0) & sb_busy[ds_rf_raddr1]; hit2 is defined likewise for port 2.
- ds_stall = ds_valid & (hit1 | hit2). This is a combinational path from the ds_* inputs.
- issue_fire = ds_valid & ~ds_stall & es_allow_in.
- Load issue: load_iss = issue_fire & ds_is_load & (ds_rf_waddr != 0).
  - When load_iss is high, cnt[ds_rf_waddr] <= LOAD_LAT at the edge.
  - Consequence: a consumer directly behind the load stalls for exactly LOAD_LAT cycles when lat_tick is constantly 1.
- Countdown: on each edge with lat_tick = 1, every nonzero cnt[n] not being reloaded decrements by 1. When lat_tick = 0, all counts hold.
- Priority per entry, highest first:
  1. flush: entry cleared.
  2. load_iss targeting this entry: reload to LOAD_LAT.
  3. lat_tick decrement.
  4. hold.
- Same-cycle load_iss to rX and rX count reaching 0: the reload wins and rX stays busy.
- flush together with load_iss: everything clears; the issued load is treated as killed.
- Reads of r0 never stall. A load whose destination is r0 sets nothing.
- A load may stall on its own source operand. Issue happens only once the stall clears, so there is no self-conflict.
- stall_cnt increments by 1 on each edge where ds_valid & ds_stall, wrapping 0xFFFFFFFF→0. It is unaffected by flush.
- At most one issue occurs per cycle. There is no full/empty condition: all 32 entries are independent.
- Reset asserted mid-operation clears all state immediately. ds_stall deasserts on the same cycle.

Decomposition:
- Shared package holds:
  - NUM_GPR = 32;
  - REG_ADDR_W = 5;
  - LOAD_LAT default constant (shared with the MEM stage);
  - a function `sb_hit(addr, re, busy)`.
- One natural sub-module: `sb_entry`, a single countdown cell with flush, load and tick inputs and a busy output. It is instantiated for entries 1..31 via generate.

Test Plan:
- LOAD_LAT=1, lat_tick=1: issue ld.w r5; next cycle ID add reads r5 (re1=1) → ds_stall=1 for exactly 1 cycle, then issue_fire=1; stall_cnt=1.
- LOAD_LAT=2: ld.w r7 issued, then an instruction reading r7 via port 2 → ds_stall high for 2 cycles, sb_busy=0x80 then 0x80 then 0x0.
- ld.w r0 issued, then read r0 → ds_stall=0, sb_busy stays 0; ld.w r3 then read r4 → no stall.
- LOAD_LAT=2, lat_tick held 0 for 3 cycles after ld.w r9 issues → sb_busy[9] stays 1 and the consumer stalls for 5 cycles total (3 frozen + 2 ticks).
- es_allow_in=0 with ds_valid=1 and ds_is_load=1 → issue_fire=0 and no entry is set. Then flush with r2 and r6 busy → sb_busy=0 on the next edge and the stalled consumer issues.
- Back-to-back ld.w r4 issues with LOAD_LAT=2 → the second issue reloads cnt[4]=2 and sb_busy[4] stays high for 2 cycles after the second issue. Then assert reset mid-countdown → sb_busy=0 and ds_stall=0 immediately.

Source files
------------

// File: rtl/load_use_interlock_pkg.sv
// load_use_interlock_pkg: shared register-file geometry, default load latency and scoreboard hit helper.
package load_use_interlock_pkg;
   localparam int NUM_GPR      = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int LOAD_LAT_DEF = 1;
   function automatic logic sb_hit(input logic [REG_ADDR_W-1:0] addr, input logic re,
                                   input logic [NUM_GPR-1:0] busy);
      return re && (addr != '0) && busy[addr];
   endfunction
endpackage

// File: rtl/load_use_interlock_if.sv
// load_use_interlock_if: ID-stage request signals in, interlock/issue/scoreboard status out.
interface load_use_interlock_if;
   import load_use_interlock_pkg::*;
   logic                  ds_valid;
   logic                  ds_rf_re1;
   logic [REG_ADDR_W-1:0] ds_rf_raddr1;
   logic                  ds_rf_re2;
   logic [REG_ADDR_W-1:0] ds_rf_raddr2;
   logic                  ds_is_load;
   logic [REG_ADDR_W-1:0] ds_rf_waddr;
   logic                  es_allow_in;
   logic                  lat_tick;
   logic                  flush;
   logic                  ds_stall;
   logic                  issue_fire;
   logic [NUM_GPR-1:0]    sb_busy;
   logic [31:0]           stall_cnt;
   modport master (
      output ds_valid, ds_rf_re1, ds_rf_raddr1, ds_rf_re2, ds_rf_raddr2,
             ds_is_load, ds_rf_waddr, es_allow_in, lat_tick, flush,
      input  ds_stall, issue_fire, sb_busy, stall_cnt
   );
   modport slave (
      input  ds_valid, ds_rf_re1, ds_rf_raddr1, ds_rf_re2, ds_rf_raddr2,
             ds_is_load, ds_rf_waddr, es_allow_in, lat_tick, flush,
      output ds_stall, issue_fire, sb_busy, stall_cnt
   );
endinterface

// File: rtl/load_use_interlock_sb_entry.sv
// load_use_interlock_sb_entry: one scoreboard countdown; flush beats reload beats tick decrement.
module load_use_interlock_sb_entry #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic i_flush,
   input  logic i_load,
   input  logic i_tick,
   output logic o_busy
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else if (i_flush) r_cnt <= '0;
      else if (i_load) r_cnt <= CNT_W'(LOAD_LAT);
      else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_busy = r_cnt != '0;
endmodule

// File: rtl/load_use_interlock.sv
// load_use_interlock: per-register load scoreboard that holds dependent instructions in ID
// until load data is forwardable, gates ID->EXE issue and counts interlock cycles.
module load_use_interlock
   import load_use_interlock_pkg::*;
#(
   parameter int LOAD_LAT = LOAD_LAT_DEF,
   parameter int CNT_W    = 3
) (
   input logic                 clk,
   input logic                 reset,
   load_use_interlock_if.slave bus
);
   logic [NUM_GPR-1:0] w_busy;
   logic               w_stall;
   logic               w_fire;
   logic               w_load_iss;
   logic [31:0]        r_stall_cnt;
   assign w_busy[0] = 1'b0;
   for (genvar i = 1; i < NUM_GPR; i++) begin : g_ent
      load_use_interlock_sb_entry #(.LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) u_ent (
         .clk     (clk),
         .reset   (reset),
         .i_flush (bus.flush),
         .i_load  (w_load_iss && bus.ds_rf_waddr == REG_ADDR_W'(i)),
         .i_tick  (bus.lat_tick),
         .o_busy  (w_busy[i])
      );
   end
   assign w_stall    = bus.ds_valid & (sb_hit(bus.ds_rf_raddr1, bus.ds_rf_re1, w_busy) |
                                       sb_hit(bus.ds_rf_raddr2, bus.ds_rf_re2, w_busy));
   // Reset also suppresses issue so nothing leaves ID while state is being cleared.
   assign w_fire     = ~reset & bus.ds_valid & ~w_stall & bus.es_allow_in;
   assign w_load_iss = w_fire & bus.ds_is_load & (bus.ds_rf_waddr != '0);
   always_ff @(posedge clk or posedge reset)
      if (reset) r_stall_cnt <= '0;
      else if (bus.ds_valid && w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
   assign bus.ds_stall   = w_stall;
   assign bus.issue_fire = w_fire;
   assign bus.sb_busy    = w_busy;
   assign bus.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_load_use_interlock.sv
// tb_load_use_interlock: directed vectors for LOAD_LAT=2 plus hand sequences for LOAD_LAT=1, flush, reload and reset.
module tb_load_use_interlock;
   logic clk = 1'b0, reset = 1'b1;
   logic v, r1, r2, ld, al, tk, fl;
   logic [4:0] a1, a2, wa;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   load_use_interlock_if if1 ();
   load_use_interlock_if if2 ();
   assign if1.ds_valid = v;  assign if2.ds_valid = v;
   assign if1.ds_rf_re1 = r1; assign if2.ds_rf_re1 = r1;
   assign if1.ds_rf_raddr1 = a1; assign if2.ds_rf_raddr1 = a1;
   assign if1.ds_rf_re2 = r2; assign if2.ds_rf_re2 = r2;
   assign if1.ds_rf_raddr2 = a2; assign if2.ds_rf_raddr2 = a2;
   assign if1.ds_is_load = ld; assign if2.ds_is_load = ld;
   assign if1.ds_rf_waddr = wa; assign if2.ds_rf_waddr = wa;
   assign if1.es_allow_in = al; assign if2.es_allow_in = al;
   assign if1.lat_tick = tk;  assign if2.lat_tick = tk;
   assign if1.flush = fl;     assign if2.flush = fl;
   load_use_interlock #(.LOAD_LAT(1), .CNT_W(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   load_use_interlock #(.LOAD_LAT(2), .CNT_W(3)) dut2 (.clk(clk), .reset(reset), .bus(if2));
   typedef struct {
      logic v, r1; logic [4:0] a1; logic r2; logic [4:0] a2; logic ld; logic [4:0] wa;
      logic al, tk, fl, st, fi; logic [31:0] bz;
   } vec_t;
   vec_t tv[19];
   function automatic vec_t mk(logic v_, logic r1_, logic [4:0] a1_, logic r2_, logic [4:0] a2_,
                               logic ld_, logic [4:0] wa_, logic al_, logic tk_, logic fl_,
                               logic st_, logic fi_, logic [31:0] bz_);
      vec_t t;
      t.v = v_; t.r1 = r1_; t.a1 = a1_; t.r2 = r2_; t.a2 = a2_; t.ld = ld_; t.wa = wa_;
      t.al = al_; t.tk = tk_; t.fl = fl_; t.st = st_; t.fi = fi_; t.bz = bz_;
      return t;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      v = 0; r1 = 0; a1 = 0; r2 = 0; a2 = 0; ld = 0; wa = 0; al = 1; tk = 1; fl = 0;
   endtask
   task automatic set_ld(input logic [4:0] d);
      idle(); v = 1; ld = 1; wa = d;
   endtask
   task automatic set_use1(input logic [4:0] s);
      idle(); v = 1; r1 = 1; a1 = s;
   endtask
   initial begin
      idle();
      tv[0]  = mk(1,0,0,0,0,1,7,1,1,0, 0,1,32'h0);
      tv[1]  = mk(1,0,0,1,7,0,0,1,1,0, 1,0,32'h80);
      tv[2]  = mk(1,0,0,1,7,0,0,1,1,0, 1,0,32'h80);
      tv[3]  = mk(1,0,0,1,7,0,0,1,1,0, 0,1,32'h0);
      tv[4]  = mk(1,0,0,0,0,1,0,1,1,0, 0,1,32'h0);
      tv[5]  = mk(1,1,0,0,0,0,0,1,1,0, 0,1,32'h0);
      tv[6]  = mk(1,0,0,0,0,1,3,1,1,0, 0,1,32'h0);
      tv[7]  = mk(1,1,4,1,4,0,0,1,1,0, 0,1,32'h8);
      tv[8]  = mk(1,0,3,0,3,0,0,1,1,0, 0,1,32'h8);
      tv[9]  = mk(0,0,0,0,0,0,0,1,1,0, 0,0,32'h0);
      tv[10] = mk(1,0,0,0,0,1,9,1,1,0, 0,1,32'h0);
      tv[11] = mk(1,1,9,0,0,0,0,1,0,0, 1,0,32'h200);
      tv[12] = mk(1,1,9,0,0,0,0,1,0,0, 1,0,32'h200);
      tv[13] = mk(1,1,9,0,0,0,0,1,0,0, 1,0,32'h200);
      tv[14] = mk(1,1,9,0,0,0,0,1,1,0, 1,0,32'h200);
      tv[15] = mk(1,1,9,0,0,0,0,1,1,0, 1,0,32'h200);
      tv[16] = mk(1,1,9,0,0,0,0,1,1,0, 0,1,32'h0);
      tv[17] = mk(1,0,0,0,0,1,2,0,1,0, 0,0,32'h0);
      tv[18] = mk(0,0,0,0,0,0,0,1,1,0, 0,0,32'h0);
      repeat (2) cyc();
      set_use1(5);
      #1;
      chk("rst_fire", {31'b0, if2.issue_fire}, 0);
      chk("rst_stall", {31'b0, if2.ds_stall}, 0);
      chk("rst_busy", if2.sb_busy, 0);
      chk("rst_cnt", if2.stall_cnt, 0);
      idle(); reset = 0;
      cyc();
      // LOAD_LAT=1 consumer right behind ld.w r5
      set_ld(5); #1;
      chk("l1_ld_fire", {31'b0, if1.issue_fire}, 1);
      cyc(); set_use1(5); #1;
      chk("l1_stall", {31'b0, if1.ds_stall}, 1);
      chk("l1_busy", if1.sb_busy, 32'h20);
      cyc(); #1;
      chk("l1_unstall", {31'b0, if1.ds_stall}, 0);
      chk("l1_fire", {31'b0, if1.issue_fire}, 1);
      cyc(); idle(); #1;
      chk("l1_stall_cnt", if1.stall_cnt, 1);
      reset = 1; cyc(); reset = 0; cyc();
      for (int i = 0; i < 19; i++) begin
         v = tv[i].v; r1 = tv[i].r1; a1 = tv[i].a1; r2 = tv[i].r2; a2 = tv[i].a2;
         ld = tv[i].ld; wa = tv[i].wa; al = tv[i].al; tk = tv[i].tk; fl = tv[i].fl;
         #1;
         chk($sformatf("vec%0d_stall", i), {31'b0, if2.ds_stall}, {31'b0, tv[i].st});
         chk($sformatf("vec%0d_fire", i), {31'b0, if2.issue_fire}, {31'b0, tv[i].fi});
         chk($sformatf("vec%0d_busy", i), if2.sb_busy, tv[i].bz);
         cyc();
      end
      idle(); #1;
      chk("tbl_stall_cnt", if2.stall_cnt, 7);
      // flush with r2/r6 busy, then flush racing a load issue
      set_ld(2); #1; chk("fl_ld2", {31'b0, if2.issue_fire}, 1);
      cyc(); set_ld(6); #1; chk("fl_busy2", if2.sb_busy, 32'h4);
      cyc(); set_use1(6); fl = 1; #1;
      chk("fl_stall", {31'b0, if2.ds_stall}, 1);
      chk("fl_busy26", if2.sb_busy, 32'h44);
      cyc(); set_ld(6); r1 = 1; a1 = 6; fl = 1; #1;
      chk("fl_cleared", if2.sb_busy, 0);
      chk("fl_issue", {31'b0, if2.issue_fire}, 1);
      cyc(); idle(); #1;
      chk("fl_kill_ld", if2.sb_busy, 0);
      chk("fl_stall_cnt", if2.stall_cnt, 8);
      // back-to-back ld.w r4
      set_ld(4); cyc(); #1;
      chk("bb_fire2", {31'b0, if2.issue_fire}, 1);
      chk("bb_busy0", if2.sb_busy, 32'h10);
      cyc(); idle(); #1; chk("bb_busy1", if2.sb_busy, 32'h10);
      cyc(); #1; chk("bb_busy2", if2.sb_busy, 32'h10);
      cyc(); #1; chk("bb_busy3", if2.sb_busy, 0);
      // reload on the same edge the count would reach zero
      set_ld(4); cyc(); idle(); cyc(); set_ld(4); #1;
      chk("co_busy", if2.sb_busy, 32'h10);
      cyc(); idle(); #1; chk("co_reload", if2.sb_busy, 32'h10);
      cyc(); set_use1(4); #1;
      chk("co_stall", {31'b0, if2.ds_stall}, 1);
      reset = 1; #1;
      chk("mr_busy", if2.sb_busy, 0);
      chk("mr_stall", {31'b0, if2.ds_stall}, 0);
      chk("mr_cnt", if2.stall_cnt, 0);
      cyc(); reset = 0; idle(); cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
